midi_msg_parser: RTL
====================

// Module: midi_msg_parser
// PURPOSE
// - Downstream of the MIDI serial byte receiver: consumes framed bytes, parses the MIDI channel-message stream.
// - Emits one-cycle note-on/note-off events (channel, note, velocity) and holds the last sounding note for the LED bank.
// - Handles running status, realtime interleave, sysex skipping and velocity-0 note-off.
// PARAMETERS
// - CH_FILTER_EN  0  1 = emit events only for channel CH_SELECT; 0 = all channels
// - CH_SELECT     0  channel (0-15) accepted when CH_FILTER_EN = 1
// PORTS
// - clk           in   1  system clock (same domain as byte receiver)
// - reset         in   1  synchronous, active-low reset
// - byte_in       in   8  received byte, valid only with byte_valid
// - byte_valid    in   1  one-cycle strobe, byte_in holds a complete byte
// - byte_err      in   1  one-cycle strobe, framing error on current byte
// - evt_valid     out  1  one-cycle pulse, event fields valid
// - evt_note_on   out  1  1 = note-on, 0 = note-off
// - evt_channel   out  4  MIDI channel of event
// - evt_note      out  7  note number
// - evt_velocity  out  7  velocity (0 for velocity-0 note-on)
// - note_led      out  7  note of last note-on; cleared by matching note-off
// - note_active   out  1  1 while note_led holds a sounding note
// - parse_err     out  1  one-cycle pulse on byte_err or orphan data byte
// - evt_count     out  16 accepted events since reset, wraps 0xFFFF -> 0
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; running status cleared (rs_valid = 0).
// - Bytes processed only in cycles with byte_valid = 1; other cycles hold state.
// - States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
// - Status 0x80-0xEF (any state): latch rs = byte_in[7:4], ch = byte_in[3:0], rs_valid = 1 -> WAIT_D1.
// - Data bytes per rs: 0x8/0x9/0xA/0xB/0xE = 2, 0xC/0xD = 1; only 0x8/0x9 produce events.
// - Data (bit7 = 0) in WAIT_D1: latch d1; 2-byte rs -> WAIT_D2; 1-byte rs -> stay WAIT_D1 (message done).
// - Data in WAIT_D2: latch d2 -> WAIT_D1 (running status); if rs is 0x8/0x9 and channel passes filter, event.
// - Data in IDLE (no running status): dropped, parse_err pulses.
// - 0xF0: rs_valid = 0 -> SYSEX; data bytes in SYSEX dropped silently (no parse_err).
// - 0xF7 or 0xF1-0xF6: rs_valid = 0 -> IDLE (system-common data bytes then dropped as orphans).
// - 0xF8-0xFF realtime: no effect on state, rs, d1 or outputs; message resumes with next data byte.
// - Event timing: evt_* registered, evt_valid high exactly the cycle after the byte_valid of the last data byte.
// - evt_* fields hold their value until the next event; evt_valid is a single-cycle pulse.
// - 0x9 with d2 = 0 -> evt_note_on = 0, evt_velocity = 0; 0x8 -> evt_note_on = 0, evt_velocity = d2.
// - note_led/note_active update same cycle as evt_valid: note-on -> note_led = note, active = 1;
//   note-off with note == note_led -> note_led = 0, active = 0; other note-off -> no change.
// - evt_count increments with each evt_valid, wraps.
// - byte_err: priority over byte_valid in same cycle; byte discarded, rs_valid = 0, -> IDLE, parse_err pulses.
// - Filtered-out channels: parsing and running status proceed; no evt_valid, no LED/count change.
// - Reset asserted mid-message: partial message discarded, no event, all outputs to reset values next edge.
// TESTING
// - 0x90,0x3C,0x64 -> one evt_valid: on=1 ch=0 note=0x3C vel=0x64; note_led=0x3C, active=1, count=1.
// - Then 0x3E,0x50,0x3C,0x00 (running status) -> two events: on 0x3E/0x50, off 0x3C/0; note_led stays 0x3E.
// - 0x91,0x40,0xF8,0x7F -> realtime ignored, one event ch=1 note=0x40 vel=0x7F.
// - 0xF0,0x12,0x34,0xF7,0x40 -> no events; parse_err pulses once (orphan 0x40), sysex bytes silent.
// - 0x90,0x3C then byte_err, then 0x40 -> no event, parse_err pulses twice, state IDLE.
// - CH_FILTER_EN=1, CH_SELECT=2: 0x93,0x30,0x40 -> no event; 0x92,0x30,0x40 -> event; reset mid 0x92,0x30 -> no event.

Source files
------------

// File: rtl/midi_msg_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : midi_msg_parser_if
// Description : Bundles the byte stream from the MIDI serial receiver with the
//               parsed event / LED outputs of midi_msg_parser.
//               master : byte source / event consumer
//               slave  : the parser itself
//   byte_in[7:0], byte_valid, byte_err         : received byte and strobes
//   evt_valid, evt_note_on, evt_channel[3:0],
//   evt_note[6:0], evt_velocity[6:0]           : note event
//   note_led[6:0], note_active                 : last sounding note
//   parse_err, evt_count[15:0]                 : error pulse, event counter
// Revision    : 1.0 - initial release
// ============================================================================
interface midi_msg_parser_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_err;
  logic        evt_valid;
  logic        evt_note_on;
  logic [3:0]  evt_channel;
  logic [6:0]  evt_note;
  logic [6:0]  evt_velocity;
  logic [6:0]  note_led;
  logic        note_active;
  logic        parse_err;
  logic [15:0] evt_count;

  modport master (
    output byte_in, byte_valid, byte_err,
    input  evt_valid, evt_note_on, evt_channel, evt_note, evt_velocity,
    input  note_led, note_active, parse_err, evt_count
  );

  modport slave (
    input  byte_in, byte_valid, byte_err,
    output evt_valid, evt_note_on, evt_channel, evt_note, evt_velocity,
    output note_led, note_active, parse_err, evt_count
  );
endinterface
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module      : midi_msg_parser
// Description : Parses the framed MIDI byte stream into note-on / note-off
//               events with running status, realtime interleave, sysex
//               skipping and velocity-0 note-off. Tracks the last sounding
//               note for the LED bank and counts accepted events.
// Ports       : clk   - system clock
//               reset - synchronous, active-low reset
//               bus   - midi_msg_parser_if.slave (byte input, event outputs)
// Parameters  : CH_FILTER_EN - 1 = emit events only for channel CH_SELECT
//               CH_SELECT    - accepted channel (0-15)
// Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_parser #(
  parameter int CH_FILTER_EN = 0,
  parameter int CH_SELECT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  midi_msg_parser_if.slave     bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT_D1 = 2'd1;
  localparam logic [1:0] c_WAIT_D2 = 2'd2;
  localparam logic [1:0] c_SYSEX   = 2'd3;

  localparam logic [3:0] c_CH_SEL  = 4'(CH_SELECT);

  // Running status is implied by the state: WAIT_D1/WAIT_D2 are only reachable
  // after a channel status byte, and every path that clears it leaves them.
  logic [1:0]  r_state;
  logic [3:0]  r_rs;
  logic [3:0]  r_ch;
  logic [6:0]  r_d1;
  logic        r_evt_valid;
  logic        r_evt_note_on;
  logic [3:0]  r_evt_channel;
  logic [6:0]  r_evt_note;
  logic [6:0]  r_evt_velocity;
  logic [6:0]  r_note_led;
  logic        r_note_active;
  logic        r_parse_err;
  logic [15:0] r_evt_count;

  logic w_is_status;
  logic w_two_byte;
  logic w_ch_pass;
  logic w_emit;
  logic w_note_on;

  assign w_is_status = bus.byte_in[7];
  // Program change (0xC) and channel pressure (0xD) carry a single data byte.
  assign w_two_byte  = (r_rs != 4'hC) && (r_rs != 4'hD);
  assign w_ch_pass   = (CH_FILTER_EN == 0) || (r_ch == c_CH_SEL);
  assign w_emit      = ((r_rs == 4'h8) || (r_rs == 4'h9)) && w_ch_pass;
  // Note-on with velocity 0 is a note-off.
  assign w_note_on   = (r_rs == 4'h9) && (bus.byte_in[6:0] != 7'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= c_IDLE;
      r_rs           <= 4'd0;
      r_ch           <= 4'd0;
      r_d1           <= 7'd0;
      r_evt_valid    <= 1'b0;
      r_evt_note_on  <= 1'b0;
      r_evt_channel  <= 4'd0;
      r_evt_note     <= 7'd0;
      r_evt_velocity <= 7'd0;
      r_note_led     <= 7'd0;
      r_note_active  <= 1'b0;
      r_parse_err    <= 1'b0;
      r_evt_count    <= 16'd0;
    end else begin
      r_evt_valid <= 1'b0;
      r_parse_err <= 1'b0;
      if (bus.byte_err) begin
        r_state     <= c_IDLE;
        r_parse_err <= 1'b1;
      end else if (bus.byte_valid) begin
        if (!w_is_status) begin
          case (r_state)
            c_IDLE: r_parse_err <= 1'b1;
            c_WAIT_D1: begin
              r_d1 <= bus.byte_in[6:0];
              if (w_two_byte) begin
                r_state <= c_WAIT_D2;
              end
            end
            c_WAIT_D2: begin
              r_state <= c_WAIT_D1;
              if (w_emit) begin
                r_evt_valid    <= 1'b1;
                r_evt_note_on  <= w_note_on;
                r_evt_channel  <= r_ch;
                r_evt_note     <= r_d1;
                r_evt_velocity <= bus.byte_in[6:0];
                r_evt_count    <= r_evt_count + 16'd1;
                if (w_note_on) begin
                  r_note_led    <= r_d1;
                  r_note_active <= 1'b1;
                end else if (r_d1 == r_note_led) begin
                  r_note_led    <= 7'd0;
                  r_note_active <= 1'b0;
                end
              end
            end
            default: ; // sysex payload is skipped silently
          endcase
        end else if (bus.byte_in[7:4] != 4'hF) begin
          r_rs    <= bus.byte_in[7:4];
          r_ch    <= bus.byte_in[3:0];
          r_state <= c_WAIT_D1;
        end else if (bus.byte_in == 8'hF0) begin
          r_state <= c_SYSEX;
        end else if (!bus.byte_in[3]) begin
          // 0xF1-0xF7: system common / end of sysex cancels running status.
          r_state <= c_IDLE;
        end
        // 0xF8-0xFF realtime bytes fall through with no effect.
      end
    end
  end

  assign bus.evt_valid    = r_evt_valid;
  assign bus.evt_note_on  = r_evt_note_on;
  assign bus.evt_channel  = r_evt_channel;
  assign bus.evt_note     = r_evt_note;
  assign bus.evt_velocity = r_evt_velocity;
  assign bus.note_led     = r_note_led;
  assign bus.note_active  = r_note_active;
  assign bus.parse_err    = r_parse_err;
  assign bus.evt_count    = r_evt_count;

endmodule
`default_nettype wire
